// File: rtl/envelope_pkg.sv
// Shared types and helpers for the ADSR envelope block.
// Build option: ADSR_EXP_RELEASE_EN selects exponential release in adsr_envelope.
package envelope_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    // Default envelope fraction width and the matching full-scale level.
    localparam int ENV_E    = 8;
    localparam int ENV_FULL = 1 << ENV_E;

    // Add with a ceiling; operands are small enough that 32 bits never wrap.
    function automatic int unsigned satAdd(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned ceiling);
        int unsigned s;
        s = a + b;
        return (s > ceiling) ? ceiling : s;
    endfunction

    // Subtract with a floor: max(a - b, floorVal) without ever going negative.
    function automatic int unsigned satSub(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned floorVal);
        if (a <= floorVal + b) begin
            return floorVal;
        end
        return a - b;
    endfunction

endpackage

// File: rtl/env_scale.sv
// Combinational sample scaler: out = (sample * level) >> E.
// A level of exactly 2**E passes the sample through unchanged.
module env_scale #(
    parameter int N = 8,
    parameter int E = 8
) (
    input  logic [N-1:0] sample_i,
    input  logic [E:0]   level_i,
    output logic [N-1:0] scaled_o
);

    logic [N+E:0] product;
    logic [N+E:0] shifted;

    // Full-width product, then drop the fraction bits; clamp guards levels above full scale.
    always_comb begin
        product  = {{(E+1){1'b0}}, sample_i} * {{N{1'b0}}, level_i};
        shifted  = product >> E;
        scaled_o = (shifted > {{(E+1){1'b0}}, {N{1'b1}}}) ? {N{1'b1}} : shifted[N-1:0];
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-note ADSR amplitude envelope applied to the positive and negative
// half-wave sine samples ahead of the PWM DACs.
// Build option: define ADSR_EXP_RELEASE_EN for exponential release
// (level -= (level >> REL_SHIFT) + 1); otherwise release is linear by release_step_i.
module adsr_envelope
    import envelope_pkg::*;
#(
    parameter int N         = 8,
    parameter int E         = ENV_E,
    parameter int REL_SHIFT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_tick_i,
    input  logic         note_on_i,
    input  logic         note_off_i,
    input  logic [E:0]   attack_step_i,
    input  logic [E:0]   decay_step_i,
    input  logic [E:0]   sustain_level_i,
    input  logic [E:0]   release_step_i,
    input  logic [N-1:0] pos_in_i,
    input  logic [N-1:0] neg_in_i,
    output logic [N-1:0] pos_out_o,
    output logic [N-1:0] neg_out_o,
    output logic [E:0]   level_o,
    output logic         busy_o
);

    localparam int         FULL     = (E == ENV_E) ? ENV_FULL : (1 << E);
    localparam logic [E:0] FULL_LVL = FULL[E:0];

    env_state_t   state_q, state_d;
    logic [E:0]   level_q;
    logic [E:0]   levelNext;
    logic [E:0]   susClamped;
    logic [N-1:0] pos_q, neg_q;
    logic [N-1:0] posScaled, negScaled;

    // Both half-waves are scaled by the level held before this tick's update.
    env_scale #(.N(N), .E(E)) uScalePos (
        .sample_i (pos_in_i),
        .level_i  (level_q),
        .scaled_o (posScaled)
    );

    env_scale #(.N(N), .E(E)) uScaleNeg (
        .sample_i (neg_in_i),
        .level_i  (level_q),
        .scaled_o (negScaled)
    );

    // Sustain targets above full scale are treated as full scale.
    always_comb begin
        susClamped = (sustain_level_i > FULL_LVL) ? FULL_LVL : sustain_level_i;
    end

    // Level the envelope would take on a tick, always derived from the current state.
    always_comb begin
        levelNext = level_q;
        unique case (state_q)
            ENV_IDLE: begin
                levelNext = level_q;
            end
            ENV_ATTACK: begin
                if (attack_step_i == '0) begin
                    levelNext = FULL_LVL;
                end else begin
                    levelNext = (E+1)'(satAdd(32'(level_q), 32'(attack_step_i), 32'(FULL)));
                end
            end
            ENV_DECAY: begin
                if (decay_step_i == '0) begin
                    levelNext = susClamped;
                end else begin
                    levelNext = (E+1)'(satSub(32'(level_q), 32'(decay_step_i), 32'(susClamped)));
                end
            end
            ENV_SUSTAIN: begin
                levelNext = susClamped;
            end
            ENV_RELEASE: begin
`ifdef ADSR_EXP_RELEASE_EN
                levelNext = (E+1)'(satSub(32'(level_q), 32'(level_q >> REL_SHIFT) + 32'd1, 32'd0));
`else
                if (release_step_i == '0) begin
                    levelNext = '0;
                end else begin
                    levelNext = (E+1)'(satSub(32'(level_q), 32'(release_step_i), 32'd0));
                end
`endif
            end
            default: begin
                levelNext = '0;
            end
        endcase
    end

    // Next state: note_on beats note_off, notes beat tick-driven phase transitions.
    always_comb begin
        state_d = state_q;
        if (note_on_i) begin
            state_d = ENV_ATTACK;
        end else if (note_off_i && (state_q == ENV_ATTACK || state_q == ENV_DECAY ||
                                    state_q == ENV_SUSTAIN)) begin
            state_d = ENV_RELEASE;
        end else if (sample_tick_i) begin
            unique case (state_q)
                ENV_ATTACK:  if (levelNext == FULL_LVL)   state_d = ENV_DECAY;
                ENV_DECAY:   if (levelNext == susClamped) state_d = ENV_SUSTAIN;
                ENV_RELEASE: if (levelNext == '0)         state_d = ENV_IDLE;
                ENV_IDLE, ENV_SUSTAIN: state_d = state_q;
                default:     state_d = ENV_IDLE;
            endcase
        end
    end

    // State moves every clock; level and the output samples only move on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENV_IDLE;
            level_q <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
        end else begin
            state_q <= state_d;
            if (sample_tick_i) begin
                level_q <= levelNext;
                pos_q   <= posScaled;
                neg_q   <= negScaled;
            end
        end
    end

`ifdef ADSR_EXP_RELEASE_EN
    logic unusedRelease;
    assign unusedRelease = ^release_step_i;
`endif

    assign pos_out_o = pos_q;
    assign neg_out_o = neg_q;
    assign level_o   = level_q;
    assign busy_o    = (state_q != ENV_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed note sequences followed by
// randomized notes/ticks, all checked against a behavioural envelope model.
// Honours ADSR_EXP_RELEASE_EN in the model when the design is built with it.
module tb_adsr_envelope;

    localparam int N    = 8;
    localparam int E    = 8;
    localparam int FULL = 256;
    localparam int RS   = 4;

    // Model phases, kept as plain integers independent of the design's encoding.
    localparam int P_IDLE    = 0;
    localparam int P_ATTACK  = 1;
    localparam int P_DECAY   = 2;
    localparam int P_SUSTAIN = 3;
    localparam int P_RELEASE = 4;

    logic         clk;
    logic         reset;
    logic         sampleTick;
    logic         noteOn;
    logic         noteOff;
    logic [E:0]   attackStep;
    logic [E:0]   decayStep;
    logic [E:0]   sustainLevel;
    logic [E:0]   releaseStep;
    logic [N-1:0] posIn;
    logic [N-1:0] negIn;
    logic [N-1:0] posOut;
    logic [N-1:0] negOut;
    logic [E:0]   level;
    logic         busy;

    int testsRun;
    int testsFailed;

    int mPhase;
    int mLevel;
    int mPos;
    int mNeg;

    adsr_envelope #(.N(N), .E(E), .REL_SHIFT(RS)) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_tick_i   (sampleTick),
        .note_on_i       (noteOn),
        .note_off_i      (noteOff),
        .attack_step_i   (attackStep),
        .decay_step_i    (decayStep),
        .sustain_level_i (sustainLevel),
        .release_step_i  (releaseStep),
        .pos_in_i        (posIn),
        .neg_in_i        (negIn),
        .pos_out_o       (posOut),
        .neg_out_o       (negOut),
        .level_o         (level),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Level after one tick in the given phase, straight from the envelope rules.
    function automatic int tickLevel(input int phase, input int lvl);
        int sus;
        int v;
        sus = (int'(sustainLevel) > FULL) ? FULL : int'(sustainLevel);
        v   = lvl;
        case (phase)
            P_ATTACK:  v = (attackStep == 0) ? FULL : ((lvl + int'(attackStep) > FULL) ? FULL : lvl + int'(attackStep));
            P_DECAY:   v = (decayStep == 0) ? sus : ((lvl - int'(decayStep) < sus) ? sus : lvl - int'(decayStep));
            P_SUSTAIN: v = sus;
            P_RELEASE: begin
`ifdef ADSR_EXP_RELEASE_EN
                v = lvl - ((lvl / (1 << RS)) + 1);
`else
                v = (releaseStep == 0) ? 0 : lvl - int'(releaseStep);
`endif
                if (v < 0) v = 0;
            end
            default:   v = lvl;
        endcase
        return v;
    endfunction

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic applyStimulus(input bit rst, input bit tick, input bit on, input bit off);
        int sus;
        int nl;
        reset      = rst;
        sampleTick = tick;
        noteOn     = on;
        noteOff    = off;
        sus = (int'(sustainLevel) > FULL) ? FULL : int'(sustainLevel);
        if (rst) begin
            mPhase = P_IDLE;
            mLevel = 0;
            mPos   = 0;
            mNeg   = 0;
        end else begin
            nl = tickLevel(mPhase, mLevel);
            if (tick) begin
                mPos = (int'(posIn) * mLevel) / FULL;
                mNeg = (int'(negIn) * mLevel) / FULL;
            end
            if (on) begin
                mPhase = P_ATTACK;
            end else if (off && (mPhase == P_ATTACK || mPhase == P_DECAY || mPhase == P_SUSTAIN)) begin
                mPhase = P_RELEASE;
            end else if (tick) begin
                if (mPhase == P_ATTACK && nl == FULL)        mPhase = P_DECAY;
                else if (mPhase == P_DECAY && nl == sus)     mPhase = P_SUSTAIN;
                else if (mPhase == P_RELEASE && nl == 0)     mPhase = P_IDLE;
            end
            if (tick) mLevel = nl;
        end
        @(posedge clk);
        #1;
        reset      = 1'b0;
        sampleTick = 1'b0;
        noteOn     = 1'b0;
        noteOff    = 1'b0;
        checkOutput("level", int'(level), mLevel);
        checkOutput("busy", int'(busy), (mPhase != P_IDLE) ? 1 : 0);
        checkOutput("posOut", int'(posOut), mPos);
        checkOutput("negOut", int'(negOut), mNeg);
        @(negedge clk);
    endtask

    task automatic ticks(input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        testsRun     = 0;
        testsFailed  = 0;
        mPhase       = P_IDLE;
        mLevel       = 0;
        mPos         = 0;
        mNeg         = 0;
        reset        = 1'b1;
        sampleTick   = 1'b0;
        noteOn       = 1'b0;
        noteOff      = 1'b0;
        attackStep   = 9'd64;
        decayStep    = 9'd16;
        sustainLevel = 9'd128;
        releaseStep  = 9'd32;
        posIn        = 8'd200;
        negIn        = 8'd100;
        @(negedge clk);

        // Reset, then idle ticks keep everything silent.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        checkOutput("idlePosOut", int'(posOut), 0);

        // Full attack to 256, decay to 128, settle in sustain.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(4);
        checkOutput("attackPeak", int'(level), 256);
        ticks(1);
        checkOutput("fullScalePass", int'(posOut), 200);
        ticks(9);
        checkOutput("sustainLevel", int'(level), 128);
        ticks(1);
        checkOutput("halfScale", int'(posOut), 100);

        // Release to idle.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(20);
        checkOutput("releasedIdle", int'(busy), 0);

        // Retrigger during release keeps the current level.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(12);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(2);
`ifndef ADSR_EXP_RELEASE_EN
        checkOutput("releaseAt64", int'(level), 64);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1);
`ifndef ADSR_EXP_RELEASE_EN
        checkOutput("retrigFrom64", int'(level), 128);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        ticks(2);

        // Zero steps and an over-range sustain target.
        attackStep   = 9'd0;
        decayStep    = 9'd0;
        sustainLevel = 9'd300;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1);
        checkOutput("zeroAttackFull", int'(level), 256);
        ticks(4);
        checkOutput("sustainClamped", int'(level), 256);

        // Release to idle, reset in the middle of a new note.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(40);
        attackStep = 9'd40;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("resetMidNote", int'(level), 0);

        // Randomized notes, ticks, steps and samples.
        for (int c = 0; c < 4000; c++) begin
            posIn = 8'($urandom_range(0, 255));
            negIn = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) begin
                attackStep   = 9'($urandom_range(0, 80));
                decayStep    = 9'($urandom_range(0, 40));
                sustainLevel = 9'($urandom_range(0, 511));
                releaseStep  = 9'($urandom_range(0, 60));
            end
            applyStimulus($urandom_range(0, 700) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 60) == 0,
                          $urandom_range(0, 25) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
